// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential fetch over a req/gnt/rvalid memory,
// a credit-guarded prefetch queue, and a first-word-fall-through decode port.
module fetch_prefetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  fetch_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t state;

  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               push;
  logic               pop;

  // mem_addr still holds the granted address while in WAIT, so it doubles as
  // the PC tag of the returning instruction.
  assign push        = (state == WAIT) && mem_rvalid && !redirect;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign count_next  = count + CNT_W'(push) - CNT_W'(pop);

  assign instr    = instr_valid ? q_instr[rd_ptr] : '0;
  assign instr_pc = instr_valid ? q_pc[rd_ptr]    : '0;

  // Fetch FSM. The occupancy after this cycle's push/pop is what the next
  // request must fit into, since that request reserves one queue slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      mem_req  <= 1'b0;
      unique case (state)
        REQ:     state <= mem_gnt ? DROP : IDLE;
        WAIT:    state <= mem_rvalid ? IDLE : DROP;
        default: state <= IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (!halt && (count < DEPTH_C)) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state    <= WAIT;
            mem_req  <= 1'b0;
            fetch_pc <= fetch_pc + PC_STEP;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (!halt && (count_next < DEPTH_C)) begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= fetch_pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // NOTE: queue storage has no reset; validity comes from count alone and the
  // decode outputs are forced to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= mem_rdata;
      q_pc[wr_ptr]    <= mem_addr;
    end
  end

  // A push into a full queue without a same-cycle pop would mean the credit
  // reservation was broken.
  property p_no_overflow;
    @(posedge clk) disable iff (rst) push |-> ((count < DEPTH_C) || pop);
  endproperty
  assert property (p_no_overflow);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: behavioural memory with configurable latency,
// expected-instruction scoreboard checked at each decode handshake.
module tb_fetch_prefetch_unit;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               halt = 1'b0;
  logic               redirect = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_gnt = 1'b0;
  logic               mem_rvalid = 1'b0;
  logic [INSTR_W-1:0] mem_rdata = '0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready = 1'b0;
  logic [ADDR_W-1:0]  fetch_pc;

  fetch_prefetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(4), .PC_INC(2), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ins;
  } exp_t;
  exp_t sb[$];

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic void expect_pc(input logic [ADDR_W-1:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem_word(pc);
    sb.push_back(e);
  endfunction

  // Memory model: decides gnt/rvalid on the falling edge for the next rise.
  bit                pend = 1'b0;
  int                pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  int                lat = 1;
  logic [ADDR_W-1:0] gnt_log[$];

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_addr);
        pend       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (mem_req && !pend && !rst) begin
      mem_gnt   = 1'b1;
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = mem_addr;
      gnt_log.push_back(mem_addr);
    end
  end

  // Decode-side monitor: every accepted instruction is checked in order.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && !redirect && instr_valid && instr_ready && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (instr_pc !== e.pc || instr !== e.ins)
        $display("FAIL deliver: got pc=%h instr=%h want pc=%h instr=%h",
                 instr_pc, instr, e.pc, e.ins);
      else passed++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    redirect_pc = '0;
    pend = 1'b0; lat = l;
    gnt_log.delete();
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin step(); n++; end
    checks++;
    if (sb.size() != 0) $display("FAIL %s_drain: %0d left after %0d cycles want 0", name, sb.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else passed++;
    checks++; if (mem_addr !== 16'h0) $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid); else passed++;
    checks++; if (instr !== 16'h0) $display("FAIL rst_instr: got %h want 0000", instr); else passed++;
    checks++; if (instr_pc !== 16'h0) $display("FAIL rst_instr_pc: got %h want 0000", instr_pc); else passed++;
    checks++; if (fetch_pc !== 16'h0) $display("FAIL rst_fetch_pc: got %h want 0000", fetch_pc); else passed++;
  endtask

  task automatic test_sequential();
    int n = 0;
    int first = -1;
    do_reset(1);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_pc(ADDR_W'(2 * i));
    while (sb.size() != 0 && n < 60) begin
      step(); n++;
      if (first < 0 && instr_valid === 1'b1) first = n;
    end
    checks++;
    if (first < 1 || first > 4) $display("FAIL seq_first_valid: got cycle %0d want 1..4", first);
    else passed++;
    checks++;
    if (sb.size() != 0 || n > 20) $display("FAIL seq_throughput: got %0d cycles with %0d left want <=20 and 0", n, sb.size());
    else passed++;
  endtask

  task automatic test_fill();
    bit late_req = 1'b0;
    int n = 0;
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt_log.size() >= 4 && mem_req === 1'b1 && !mem_gnt) late_req = 1'b1;
    end
    checks++; if (gnt_log.size() != 4) $display("FAIL fill_grants: got %0d want 4", gnt_log.size()); else passed++;
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      checks++;
      if (gnt_log[i] !== ADDR_W'(2 * i)) $display("FAIL fill_addr%0d: got %h want %h", i, gnt_log[i], ADDR_W'(2 * i));
      else passed++;
    end
    checks++; if (late_req) $display("FAIL fill_req_idle: got mem_req=1 want 0 with queue full"); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL fill_mem_req: got %b want 0", mem_req); else passed++;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) $display("FAIL fill_head: got v=%b pc=%h want v=1 pc=0000", instr_valid, instr_pc); else passed++;
    checks++; if (fetch_pc !== 16'h0008) $display("FAIL fill_fetch_pc: got %h want 0008", fetch_pc); else passed++;
    for (int i = 0; i < 6; i++) expect_pc(ADDR_W'(2 * i));
    instr_ready = 1'b1;
    while (mem_req !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0008) $display("FAIL fill_resume: got req=%b addr=%h want req=1 addr=0008", mem_req, mem_addr); else passed++;
    wait_drained("fill", 40);
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    do_reset(3);
    instr_ready = 1'b1;
    expect_pc(16'h0000);
    while (!(pend && pend_addr == 16'h0002) && n < 40) begin step(); n++; end
    step();
    checks++; if (sb.size() != 0 || !pend) $display("FAIL rw_setup: got left=%0d pend=%b want 0 and 1", sb.size(), pend); else passed++;
    redirect = 1'b1; redirect_pc = 16'h0100;
    sb.delete();
    expect_pc(16'h0100); expect_pc(16'h0102); expect_pc(16'h0104);
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rw_empty: got %b want 0", instr_valid); else passed++;
    checks++; if (fetch_pc !== 16'h0100) $display("FAIL rw_fetch_pc: got %h want 0100", fetch_pc); else passed++;
    wait_drained("rw", 80);
  endtask

  task automatic test_redirect_collide();
    int n = 0;
    do_reset(1);
    while (!(mem_rvalid && instr_valid === 1'b1) && n < 20) begin step(); n++; end
    checks++; if (!(mem_rvalid && instr_valid === 1'b1)) $display("FAIL rc_setup: got rvalid=%b valid=%b want 1 1", mem_rvalid, instr_valid); else passed++;
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    sb.delete();
    expect_pc(16'h0200); expect_pc(16'h0202);
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rc_empty: got %b want 0", instr_valid); else passed++;
    checks++; if (mem_req !== 1'b0 || fetch_pc !== 16'h0200) $display("FAIL rc_state: got req=%b pc=%h want 0 0200", mem_req, fetch_pc); else passed++;
    wait_drained("rc", 40);
  endtask

  task automatic test_halt();
    int n = 0;
    bit saw_req = 1'b0;
    do_reset(3);
    instr_ready = 1'b1;
    expect_pc(16'h0000);
    while (!pend && n < 20) begin step(); n++; end
    halt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_req === 1'b1) saw_req = 1'b1;
    end
    checks++; if (saw_req || gnt_log.size() != 1) $display("FAIL halt_no_issue: got req_seen=%b grants=%0d want 0 1", saw_req, gnt_log.size()); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL halt_inflight_push: got %0d undelivered want 0", sb.size()); else passed++;
    checks++; if (fetch_pc !== 16'h0002) $display("FAIL halt_fetch_pc: got %h want 0002", fetch_pc); else passed++;
    expect_pc(16'h0002); expect_pc(16'h0004);
    halt = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin step(); n++; end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) $display("FAIL halt_resume: got req=%b addr=%h want 1 0002", mem_req, mem_addr); else passed++;
    wait_drained("halt", 40);
  endtask

  task automatic test_wrap_and_reset();
    int n = 0;
    do_reset(3);
    redirect = 1'b1; redirect_pc = 16'h1234; step();
    redirect_pc = 16'h5678; step();
    redirect_pc = 16'hFFFE; step();
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b0 || fetch_pc !== 16'hFFFE) $display("FAIL wrap_redirect_hold: got req=%b pc=%h want 0 FFFE", mem_req, fetch_pc); else passed++;
    while (gnt_log.size() < 2 && n < 30) begin step(); n++; end
    checks++; if (gnt_log.size() < 2) $display("FAIL wrap_grants: got %0d want 2", gnt_log.size()); else passed++;
    if (gnt_log.size() >= 2) begin
      checks++; if (gnt_log[0] !== 16'hFFFE) $display("FAIL wrap_addr0: got %h want FFFE", gnt_log[0]); else passed++;
      checks++; if (gnt_log[1] !== 16'h0000) $display("FAIL wrap_addr1: got %h want 0000", gnt_log[1]); else passed++;
    end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFE || instr !== mem_word(16'hFFFE)) $display("FAIL wrap_head: got v=%b pc=%h i=%h want 1 FFFE %h", instr_valid, instr_pc, instr, mem_word(16'hFFFE)); else passed++;
    // Reset lands while the wrapped request is still awaiting its response.
    rst = 1'b1;
    step();
    rst = 1'b0; halt = 1'b1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0) $display("FAIL wrst_mem: got req=%b addr=%h want 0 0000", mem_req, mem_addr); else passed++;
    checks++; if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0) $display("FAIL wrst_head: got v=%b i=%h pc=%h want 0 0000 0000", instr_valid, instr, instr_pc); else passed++;
    checks++; if (fetch_pc !== 16'h0) $display("FAIL wrst_fetch_pc: got %h want 0000", fetch_pc); else passed++;
    for (int i = 0; i < 6; i++) step();
    checks++; if (pend) $display("FAIL wrst_late_sent: late response still pending"); else passed++;
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL wrst_late_ignored: got v=%b req=%b want 0 0", instr_valid, mem_req); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_redirect_wait();
    test_redirect_collide();
    test_halt();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end; successor to the single-cycle PC register plus instruction-memory path.
- Generates sequential fetch addresses to a multi-cycle instruction memory using a request/grant/response handshake.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry prefetch queue.
- Presents them first-word-fall-through to decode with a valid/ready handshake, and supports branch redirect (flush) and halt.

Parameters:
ADDR_W, 16, width of PC and memory address
INSTR_W, 16, instruction width
DEPTH, 4, prefetch queue entries; power of 2, >= 2
PC_INC, 2, byte increment between sequential fetches
RESET_PC, 0, fetch PC loaded at reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
halt  in  1  blocks issue of new fetch requests
redirect  in  1  branch taken / PC load; flushes queue
redirect_pc  in  ADDR_W  new fetch PC when redirect=1
mem_req  out  1  fetch request valid
mem_addr  out  ADDR_W  fetch address; stable while mem_req=1
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  response data valid this cycle
mem_rdata  in  INSTR_W  response instruction
instr_valid  out  1  queue head valid
instr  out  INSTR_W  queue head instruction
instr_pc  out  ADDR_W  PC of queue head
instr_ready  in  1  decode consumes head when instr_valid=1
fetch_pc  out  ADDR_W  next address to be requested (debug / PC+inc source)

Behaviour:
- Reset, sampled on a clk edge:
  - fetch_pc=RESET_PC; queue empty with pointers 0; state IDLE.
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0.
  - rst overrides every other input, including mid-transaction; a response arriving in the cycle after reset is ignored.
- Credit rule:
  - credits_used = queue occupancy + (1 if a request is granted but not yet answered).
  - Issue is permitted only if credits_used < DEPTH, so the queue can never overflow.
  - At most one request is outstanding.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE: if !halt and issue permitted -> REQ. mem_req is registered, so the first request appears one cycle after leaving reset or IDLE.
  - REQ: mem_req=1, mem_addr=fetch_pc. On mem_gnt -> WAIT and fetch_pc += PC_INC, modulo 2^ADDR_W.
    - mem_req is held, with no address change, until granted. halt does not withdraw a pending request.
  - WAIT: on mem_rvalid, push {fetch address, mem_rdata} into the queue. Then go to REQ if !halt and issue is permitted after the push, else IDLE.
    - Back-to-back throughput: one instruction per 2 cycles with a zero-wait memory.
  - DROP: the next mem_rvalid is discarded with no push, then -> IDLE.
- Queue / decode handshake:
  - instr_valid = queue not empty; instr and instr_pc are driven combinationally from the head entry.
  - Pop when instr_valid && instr_ready. Push and pop in the same cycle leave occupancy unchanged, including when the queue is full: the push is legal because credit was reserved.
  - Pointers wrap modulo DEPTH.
  - instr_ready while the queue is empty has no effect.
- Redirect (highest priority after rst), taking effect at the clock edge:
  - Queue flushed to empty, and any same-cycle pop or push is discarded.
  - fetch_pc = redirect_pc.
  - State from IDLE or DROP -> IDLE; the next request to redirect_pc appears after IDLE re-evaluates.
  - State from REQ without gnt -> IDLE; the request is withdrawn, which the memory permits.
  - State from REQ with gnt, or from WAIT without rvalid -> DROP; the stale response is discarded.
  - State from WAIT with rvalid in the same cycle -> IDLE; the data is discarded.
  - redirect held high for several cycles re-flushes each cycle; the last redirect_pc wins.
- halt:
  - Only gates new issue; an in-flight response still pushes.
  - Decode may continue to drain the queue.
  - Deasserting halt resumes fetching from fetch_pc.
- Memory protocol assumptions enforced by the bench:
  - Responses arrive in order, at least one cycle after grant.
  - mem_rvalid is never asserted with nothing outstanding.

Test Plan:
- Reset then zero-wait memory (gnt=1, rvalid the cycle after grant), instr_ready=1 -> instr_pc sequence 0x0000, 0x0002, 0x0004, ...; instr_valid first high within 4 cycles of reset release; instrs match memory contents.
- instr_ready=0 with DEPTH=4 -> exactly 4 entries fill (PCs 0,2,4,6), mem_req stays 0 afterwards; then raise instr_ready -> drains in order and fetch resumes at 0x0008.
- 3-cycle memory latency, redirect to 0x0100 asserted while in WAIT -> the stale response is not delivered; the next instr_pc is 0x0100 and the queue is empty the cycle after redirect.
- redirect in the same cycle as mem_rvalid and instr_ready with a non-empty queue -> no pop or push takes effect, the queue is empty, and fetch restarts at redirect_pc.
- halt=1 with one request outstanding -> that instruction is pushed and no further mem_req; after halt=0 the next mem_addr = fetch_pc.
- fetch_pc=0xFFFE sequential fetch -> the next request address wraps to 0x0000; rst asserted mid-WAIT -> all outputs return to reset values and the late response is ignored.
